// File: rtl/bitwise_serial_pkg.sv
// Shared encodings for the bit-serial logic engine: op select codes and FSM states.
package bitwise_serial_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Slice counter width; a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-wide bitwise operation (AND/OR/XOR/NAND) on one operand slice.
module bitwise_slice
  import bitwise_serial_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [0:SLICE-1] a_i,
  input  logic [0:SLICE-1] b_i,
  input  logic [1:0]       op_i,
  output logic [0:SLICE-1] y_o
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves y_o unassigned (no latch).
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_serial_unit.sv
// Bit-serial bitwise engine: one SLICE-bit slice per clock, valid/ready in and out.
// Optional `any` output (OR-reduction of out) is enabled by defining BITWISE_SERIAL_ANY_EN.
module bitwise_serial_unit
  import bitwise_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out
`ifdef BITWISE_SERIAL_ANY_EN
  ,
  output logic             any
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("bitwise_serial_unit: SLICE must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [0:WIDTH-1] a_q, a_d;
  logic [0:WIDTH-1] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [0:WIDTH-1] out_q, out_d;
  logic [0:SLICE-1] slice_a, slice_b, slice_y;
`ifdef BITWISE_SERIAL_ANY_EN
  logic             any_q, any_d;
`endif

  assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

  bitwise_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .op_i (op_q),
    .y_o  (slice_y)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    out_d     = out_q;
`ifdef BITWISE_SERIAL_ANY_EN
    any_d     = any_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          out_d   = '0;
          idx_d   = '0;
`ifdef BITWISE_SERIAL_ANY_EN
          any_d   = 1'b0;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        out_d[int'(idx_q)*SLICE +: SLICE] = slice_y;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
`ifdef BITWISE_SERIAL_ANY_EN
          any_d   = |out_d;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q <= state_d;
    end
  end

  // NOTE: captured operands are plain registers, so they take the reset value like the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      out_q <= '0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      out_q <= out_d;
    end
  end

`ifdef BITWISE_SERIAL_ANY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign any = any_q;
`endif

  assign out = out_q;

endmodule

// File: tb/tb_bitwise_serial_unit.sv
// Directed bench for bitwise_serial_unit: SLICE=4 and SLICE=16 instances, hand-computed results.
module tb_bitwise_serial_unit;

  logic clk = 1'b0;
  logic reset;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [0:15] a4, b4, out4;
  logic [1:0]  op4;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [0:15] a16, b16, out16;
  logic [1:0]  op16;

`ifdef BITWISE_SERIAL_ANY_EN
  logic any4, any16;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bitwise_serial_unit #(.WIDTH(16), .SLICE(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .op        (op4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out       (out4)
`ifdef BITWISE_SERIAL_ANY_EN
    ,
    .any       (any4)
`endif
  );

  bitwise_serial_unit #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .op        (op16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out       (out16)
`ifdef BITWISE_SERIAL_ANY_EN
    ,
    .any       (any16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full transaction on the SLICE=4 unit: accept, 4-cycle latency, result, handshake back to IDLE.
  task automatic run4(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic [1:0] opv, input logic [15:0] exp);
    int cyc;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready4), 32'd1);
    a4 = av; b4 = bv; op4 = opv; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    a4 = ~av; b4 = ~bv; op4 = ~opv;
    cyc = 0;
    while (out_valid4 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_out"}, 32'(out4), 32'(exp));
    check({tag, "_busy_ready"}, 32'(in_ready4), 32'd0);
`ifdef BITWISE_SERIAL_ANY_EN
    check({tag, "_any"}, 32'(any4), 32'(exp != 16'h0000));
`endif
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready4), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid4), 32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; op4 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready4), 32'd1);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_out", 32'(out4), 32'd0);
    reset = 1'b0;

    run4("or",   16'hF0F0, 16'h0FF0, 2'b01, 16'hFFF0);
    run4("and",  16'hF0F0, 16'h0FF0, 2'b00, 16'h00F0);
    run4("xor",  16'hF0F0, 16'h0FF0, 2'b10, 16'hFF00);
    run4("nand", 16'hF0F0, 16'h0FF0, 2'b11, 16'hFF0F);

    // Backpressure: result must hold while out_ready stays low and inputs churn.
    @(negedge clk);
    a4 = 16'hF0F0; b4 = 16'h0FF0; op4 = 2'b10; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    cyc = 0;
    while (out_valid4 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_out", 32'(out4), 32'h0000FF00);
    for (int i = 0; i < 10; i++) begin
      a4 = 16'($urandom); b4 = 16'($urandom); op4 = 2'($urandom); in_valid4 = i[0];
      @(negedge clk);
      check("bp_hold_out", 32'(out4), 32'h0000FF00);
      check("bp_hold_ready", 32'(in_ready4), 32'd0);
      check("bp_hold_valid", 32'(out_valid4), 32'd1);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    #1;
    check("bp_no_turnaround", 32'(in_ready4), 32'd0);
    @(negedge clk);
    out_ready4 = 1'b0;
    check("bp_release_ready", 32'(in_ready4), 32'd1);
    check("bp_release_valid", 32'(out_valid4), 32'd0);

    // Reset in the middle of BUSY, after slices 0 and 1 have been written.
    @(negedge clk);
    a4 = 16'hF0F0; b4 = 16'h0FF0; op4 = 2'b01; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_partial", 32'(out4), 32'h0000FF00);
    reset = 1'b1;
    #1;
    check("mid_rst_out", 32'(out4), 32'd0);
    check("mid_rst_valid", 32'(out_valid4), 32'd0);
    check("mid_rst_ready", 32'(in_ready4), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run4("post_rst", 16'h1234, 16'h00FF, 2'b11, 16'hFFCB);

    run4("zero_or", 16'h0000, 16'h0000, 2'b01, 16'h0000);
    run4("one_or",  16'h0001, 16'h0000, 2'b01, 16'h0001);

    // Single-slice build: BUSY lasts exactly one cycle.
    @(negedge clk);
    check("s16_in_ready", 32'(in_ready16), 32'd1);
    a16 = 16'h1234; b16 = 16'h00FF; op16 = 2'b10; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; op16 = 2'b00;
    check("s16_busy_valid", 32'(out_valid16), 32'd0);
    @(negedge clk);
    check("s16_valid", 32'(out_valid16), 32'd1);
    check("s16_out", 32'(out16), 32'h000012CB);
`ifdef BITWISE_SERIAL_ANY_EN
    check("s16_any", 32'(any16), 32'd1);
`endif
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    check("s16_idle_ready", 32'(in_ready16), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bitwise_serial_unit.md
Name: bitwise_serial_unit

Overview:
- Parametrised successor to the fixed 16-bit bitwise gate arrays in the layer-1 library.
- Computes a selectable bitwise operation (AND/OR/XOR/NAND) of two WIDTH-bit operands.
- Processes the operands one SLICE-bit slice per clock and returns the result through a registered valid/ready interface.
- Serves as the shared bit-logic engine for the upper layers, trading latency for area.

Parameters:
- WIDTH, 16, operand/result width; must be ≥1.
- SLICE, 4, bits processed per cycle; must be ≥1 and divide WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request strobe.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  operand A, declared [0:WIDTH-1].
- b  input  WIDTH  operand B, declared [0:WIDTH-1].
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result, declared [0:WIDTH-1].

Behaviour:
- Reset and clocking:
  - One clock (clk); reset is asynchronous and active-high.
  - While reset is asserted: state=IDLE, in_ready=1, out_valid=0, out=0, slice index=0, captured a/b/op=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture a, b and op, clear out to 0, set idx=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, write result bits [idx*SLICE : idx*SLICE+SLICE-1] using the captured operands, then increment idx.
  - Slice 0 (indices 0..SLICE-1) is processed first.
  - After the cycle that writes slice NSLICE-1, go to DONE.
- DONE:
  - out_valid=1, in_ready=0; out is held stable.
  - On out_ready=1, go to IDLE. in_ready rises the following cycle; there is no same-cycle turnaround.
- Latency:
  - Request accepted on edge T gives out_valid=1 after edge T+NSLICE.
  - SLICE=WIDTH gives 1-cycle latency (BUSY lasts one cycle).
- Inputs ignored outside IDLE:
  - in_valid and the a/b/op values are ignored while not in IDLE.
  - Input changes after capture do not affect the result.
- out_ready is ignored outside DONE.
- op values map exactly to the four listed operations; there is no illegal encoding.
- Reset mid-BUSY or mid-DONE aborts the operation with no output; all outputs return to reset values immediately.

Optional Feature:
- Macro: BITWISE_SERIAL_ANY_EN.
- Defined: adds output port `any` (1 bit), registered, equal to the OR-reduction of out.
  - Updated alongside out; valid when out_valid=1.
  - 0 on reset and while BUSY.
- Not defined: port `any` and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bitwise_serial_pkg holds:
  - op encoding constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11;
  - state encoding constants for IDLE/BUSY/DONE.
- Sub-module bitwise_slice: combinational SLICE-wide op on two slices, instantiated once and driven by a mux on idx.

Test Plan:
- WIDTH=16, SLICE=4, a=16'hF0F0, b=16'h0FF0, op=01 -> out=16'hFFF0, out_valid rises exactly 4 cycles after accept.
- Same operands, op=00/10/11 -> out=16'h00F0 / 16'hFF00 / 16'hFF0F respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggle a/b/in_valid -> out stable, in_ready=0, no new capture; out_ready=1 -> in_ready=1 next cycle.
- Reset asserted at BUSY cycle 2 -> out=0, out_valid=0, in_ready=1 immediately; a new request afterwards completes correctly.
- SLICE=16 build, a=16'h1234, b=16'h00FF, op=10 -> out=16'h12CB, 1-cycle latency.
- With BITWISE_SERIAL_ANY_EN: a=b=0, op=01 -> any=0; a=16'h0001, b=0, op=01 -> any=1.
